// File: rtl/reg_file_sb_pkg.sv
// Shared definitions for the scoreboarded register file: default sizing,
// register-address type and the zero-register helper.
package reg_file_sb_pkg;

  localparam int unsigned kW      = 8;
  localparam int unsigned kA      = 4;
  localparam int unsigned kNr     = 3;
  localparam int unsigned kMaxLd  = 2;
  localparam int unsigned kZeroReg = 0;

  typedef logic [kA-1:0] reg_addr_t;

  // Width of the outstanding-load counter for a given load limit.
  function automatic int unsigned pend_w(input int unsigned max_ld);
    return $clog2(max_ld + 1);
  endfunction

  // True when the address is the hardwired zero register of a ZERO_R0 build.
  function automatic bit is_zero_reg(input int unsigned addr, input bit zero_r0);
    return zero_r0 && (addr == kZeroReg);
  endfunction

endpackage

// File: rtl/reg_file_sb_if.sv
// Controller-side bundle of the register file: read ports, ALU write port,
// load issue handshake and load-return handshake.
interface reg_file_sb_if
  import reg_file_sb_pkg::*;
#(
  parameter int unsigned W     = kW,
  parameter int unsigned A     = kA,
  parameter int unsigned NR    = kNr,
  parameter int unsigned MAXLD = kMaxLd
);

  localparam int unsigned PW = pend_w(MAXLD);

  logic [NR-1:0][A-1:0] RdAddr;
  logic [NR-1:0][W-1:0] RdData;
  logic [NR-1:0]        RdBusy;
  logic                 WrEn;
  logic [A-1:0]         WrAddr;
  logic [W-1:0]         WrData;
  logic                 LdIssue;
  logic [A-1:0]         LdAddr;
  logic                 LdIssueReady;
  logic                 LdRetValid;
  logic [A-1:0]         LdRetAddr;
  logic [W-1:0]         LdRetData;
  logic                 LdRetReady;
  logic [PW-1:0]        Pending;
  logic                 ProtoErr;

  modport master (
    output RdAddr, WrEn, WrAddr, WrData, LdIssue, LdAddr,
           LdRetValid, LdRetAddr, LdRetData,
    input  RdData, RdBusy, LdIssueReady, LdRetReady, Pending, ProtoErr
  );

  modport slave (
    input  RdAddr, WrEn, WrAddr, WrData, LdIssue, LdAddr,
           LdRetValid, LdRetAddr, LdRetData,
    output RdData, RdBusy, LdIssueReady, LdRetReady, Pending, ProtoErr
  );

endinterface

// File: rtl/reg_scoreboard.sv
// Load scoreboard: per-register busy bits, outstanding-load counter, sticky
// protocol-error flag and the issue/return ready terms.
module reg_scoreboard
  import reg_file_sb_pkg::*;
#(
  parameter int unsigned A       = kA,
  parameter int unsigned MAXLD   = kMaxLd,
  parameter int unsigned ZERO_R0 = 0
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     wr_en,
  input  logic [A-1:0]             wr_addr,
  input  logic                     ld_issue,
  input  logic [A-1:0]             ld_addr,
  input  logic                     ld_ret_valid,
  input  logic [A-1:0]             ld_ret_addr,
  output logic [(2**A)-1:0]        busy,
  output logic [pend_w(MAXLD)-1:0] pending,
  output logic                     proto_err,
  output logic                     issue_ready_c,
  output logic                     ret_ready_c,
  output logic                     ret_accept_c
);

  localparam int unsigned NREG = 2**A;
  localparam int unsigned PW   = pend_w(MAXLD);
  localparam bit          kZr  = (ZERO_R0 != 0);

  logic issue_acc;
  logic ret_err;
  logic waw_err;

  // Ready terms depend only on current state and inputs, never on the valids.
  always_comb begin
    issue_ready_c = (pending < PW'(MAXLD)) && !busy[ld_addr];
    issue_acc     = ld_issue && issue_ready_c;
    ret_ready_c   = !(wr_en && (wr_addr == ld_ret_addr));
    ret_accept_c  = ld_ret_valid && ret_ready_c;
    ret_err       = ret_accept_c &&
                    ((pending == '0) ||
                     (!busy[ld_ret_addr] && !is_zero_reg(32'(ld_ret_addr), kZr)));
    waw_err       = wr_en && busy[wr_addr];
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      busy      <= '0;
      pending   <= '0;
      proto_err <= 1'b0;
    end else begin
      if (issue_acc && !ret_accept_c) begin
        pending <= pending + PW'(1);
      end else if (!issue_acc && ret_accept_c && (pending != '0)) begin
        pending <= pending - PW'(1);
      end
      // Clear-then-set so a fresh issue wins over a stray return to the same slot.
      for (int i = 0; i < NREG; i++) begin
        if (ret_accept_c && (ld_ret_addr == A'(i))) begin
          busy[i] <= 1'b0;
        end
        if (issue_acc && (ld_addr == A'(i)) && !is_zero_reg(32'(ld_addr), kZr)) begin
          busy[i] <= 1'b1;
        end
      end
      if (ret_err || waw_err) begin
        proto_err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_file_sb.sv
// Scoreboarded register file: storage, ALU/load-return write mux and read ports.
// Define REGFILE_BYPASS_EN to forward same-cycle accepted writes onto the reads.
module reg_file_sb
  import reg_file_sb_pkg::*;
#(
  parameter int unsigned W       = kW,
  parameter int unsigned A       = kA,
  parameter int unsigned NR      = kNr,
  parameter int unsigned MAXLD   = kMaxLd,
  parameter int unsigned ZERO_R0 = 0
) (
  input  logic        Clk,
  input  logic        Reset,
  reg_file_sb_if.slave bus
);

  localparam int unsigned NREG = 2**A;
  localparam bit          kZr  = (ZERO_R0 != 0);

  logic [W-1:0]         regs [NREG];
  logic [NREG-1:0]      busy;
  logic                 issue_ready_c;
  logic                 ret_ready_c;
  logic                 ret_accept_c;
  logic [NR-1:0][W-1:0] rd_data_c;
  logic [NR-1:0]        rd_busy_c;

  reg_scoreboard #(
    .A       (A),
    .MAXLD   (MAXLD),
    .ZERO_R0 (ZERO_R0)
  ) u_scoreboard (
    .Clk           (Clk),
    .Reset         (Reset),
    .wr_en         (bus.WrEn),
    .wr_addr       (bus.WrAddr),
    .ld_issue      (bus.LdIssue),
    .ld_addr       (bus.LdAddr),
    .ld_ret_valid  (bus.LdRetValid),
    .ld_ret_addr   (bus.LdRetAddr),
    .busy          (busy),
    .pending       (bus.Pending),
    .proto_err     (bus.ProtoErr),
    .issue_ready_c (issue_ready_c),
    .ret_ready_c   (ret_ready_c),
    .ret_accept_c  (ret_accept_c)
  );

  assign bus.LdIssueReady = issue_ready_c;
  assign bus.LdRetReady   = ret_ready_c;

  // Both write ports may fire together; the return handshake keeps their addresses apart.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else begin
      if (bus.WrEn && !is_zero_reg(32'(bus.WrAddr), kZr)) begin
        regs[bus.WrAddr] <= bus.WrData;
      end
      if (ret_accept_c && !is_zero_reg(32'(bus.LdRetAddr), kZr)) begin
        regs[bus.LdRetAddr] <= bus.LdRetData;
      end
    end
  end

  always_comb begin
    rd_data_c = '0;
    rd_busy_c = '0;
    for (int p = 0; p < NR; p++) begin
      if (!is_zero_reg(32'(bus.RdAddr[p]), kZr)) begin
        rd_data_c[p] = regs[bus.RdAddr[p]];
      end
      rd_busy_c[p] = busy[bus.RdAddr[p]];
`ifdef REGFILE_BYPASS_EN
      if (!is_zero_reg(32'(bus.RdAddr[p]), kZr)) begin
        if (bus.WrEn && (bus.WrAddr == bus.RdAddr[p])) begin
          rd_data_c[p] = bus.WrData;
        end else if (ret_accept_c && (bus.LdRetAddr == bus.RdAddr[p])) begin
          rd_data_c[p] = bus.LdRetData;
        end
      end
      if (ret_accept_c && (bus.LdRetAddr == bus.RdAddr[p])) begin
        rd_busy_c[p] = 1'b0;
      end
`endif
    end
  end

  assign bus.RdData = rd_data_c;
  assign bus.RdBusy = rd_busy_c;

endmodule
